missile_slot_allocator: RTL and testbench
=========================================

# missile_slot_allocator

Consumes fire pulses from the shooting-cooldown stage and turns each into a live missile in a fixed pool of missile slots. Allocates the lowest-index free slot, latches spawn coordinates, moves each missile upward once per frame and frees slots on hit or on reaching the top of the screen. Sits between the player/enemy shooting logic and the missile drawing and collision blocks.

## Interface
- MISSILE_COUNT, 4, number of missile slots (1..16)
- COORD_WIDTH, 11, pixel coordinate width
- MISSILE_SPEED, 4, pixels moved per frame (must be > 0 and < 2^COORD_WIDTH)
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per video frame
- shooting_pulse  in  1  one-cycle fire request
- spawn_x  in  COORD_WIDTH  spawn X, sampled when shooting_pulse is high
- spawn_y  in  COORD_WIDTH  spawn Y, sampled when shooting_pulse is high
- missile_hit  in  MISSILE_COUNT  per-slot collision, level, from collision logic
- missile_active  out  MISSILE_COUNT  slot holds a live missile (ARMED or FLYING)
- missile_x  out  MISSILE_COUNT*COORD_WIDTH  packed X per slot, slot i at [i*COORD_WIDTH +: COORD_WIDTH]
- missile_y  out  MISSILE_COUNT*COORD_WIDTH  packed Y per slot, same packing
- active_count  out  $clog2(MISSILE_COUNT+1)  number of active slots
- launch_dropped  out  1  one-cycle pulse: fire request discarded

## Operation
- Per-slot state machine: FREE, ARMED, FLYING.
- FREE→ARMED: slot selected by allocation; X/Y loaded from the request coordinates.
- ARMED→FLYING: next startOfFrame; Y is not changed on that frame.
- FLYING, startOfFrame: if Y < MISSILE_SPEED → FREE, else Y ← Y − MISSILE_SPEED (no wrap-around ever). X is constant.
- ARMED or FLYING with missile_hit[i]=1 → FREE. Hit has priority over movement in the same cycle.
- missile_hit on a FREE slot is ignored.
- Allocation: on shooting_pulse, pick the lowest-index slot whose registered state is FREE. A slot freed in the same cycle is not allocatable until the next cycle.
- No free slot: request dropped, launch_dropped=1 for one cycle (see Configuration).
- X/Y registers of a FREE slot hold their last value; consumers qualify with missile_active.
- active_count = popcount of missile_active, registered alongside it.
- Reset (any time, including mid-flight): all slots FREE, missile_x/missile_y = 0, missile_active = 0, active_count = 0, launch_dropped = 0, pending queue (if present) empty.

## Timing
- shooting_pulse at cycle n → missile_active[i]=1 and coordinates valid at n+1.
- missile_hit[i] at cycle n → missile_active[i]=0 at n+1.
- Movement update visible the cycle after startOfFrame.
- shooting_pulse coincident with startOfFrame: new slot enters ARMED and does not move on that frame.
- launch_dropped asserted at n+1 for a request at n.
- All outputs registered; no combinational input→output paths.

## Configuration
- MISSILE_FIRE_QUEUE_EN defined: one-entry pending register. A request with no free slot stores its spawn_x/spawn_y in the pending register instead of being dropped. The pending entry is allocated into the first slot observed FREE on a later cycle, with the same lowest-index rule and one-cycle latency. A new request arriving while the pending entry is full, with no free slot, pulses launch_dropped and is discarded; the existing pending entry is kept. If a new request and a pending entry are both waiting when a slot is free, the pending entry is allocated first and the new request becomes the pending entry.
- Not defined: no pending storage. Every request with no free slot is dropped with launch_dropped.

## Test plan
- Reset, then shooting_pulse with spawn_x=100, spawn_y=400 → next cycle missile_active=4'b0001, slot0 X=100 Y=400, active_count=1. Two startOfFrame pulses → Y=400 then 396.
- Slot0 FLYING at Y=5, speed 4, then 2 startOfFrame pulses → Y=1, then slot FREE; active_count returns to 0 and Y is never wrapped.
- 4 pulses fill all slots; a 5th pulse → launch_dropped=1 one cycle (macro off). With the macro on, the 5th pulse is held; missile_hit[2] then refills slot 2 with the 5th request's coordinates two cycles after the hit.
- missile_hit[1] and shooting_pulse in the same cycle with only slot 1 active among slots 0–1 → slot 0 allocated, slot 1 freed; missile_active=2'b01 in the low bits.
- Pulse coincident with startOfFrame → slot ARMED, Y unchanged for that frame, moves on the following frame.
- resetN asserted with 3 missiles flying → all outputs 0 immediately; first pulse after release allocates slot 0.

Source files
------------

// File: rtl/missile_slot_allocator.sv
// Missile slot pool: lowest-index allocation, per-frame upward motion, release on hit or top.
// Optional MISSILE_FIRE_QUEUE_EN adds a one-entry pending fire request.
module missile_slot_allocator #(
    parameter int unsigned MISSILE_COUNT = 4,
    parameter int unsigned COORD_WIDTH   = 11,
    parameter int unsigned MISSILE_SPEED = 4
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   startOfFrame,
    input  logic                                   shooting_pulse,
    input  logic [COORD_WIDTH-1:0]                 spawn_x,
    input  logic [COORD_WIDTH-1:0]                 spawn_y,
    input  logic [MISSILE_COUNT-1:0]               missile_hit,
    output logic [MISSILE_COUNT-1:0]               missile_active,
    output logic [MISSILE_COUNT*COORD_WIDTH-1:0]   missile_x,
    output logic [MISSILE_COUNT*COORD_WIDTH-1:0]   missile_y,
    output logic [$clog2(MISSILE_COUNT+1)-1:0]     active_count,
    output logic                                   launch_dropped
);

    localparam int unsigned CNT_W = $clog2(MISSILE_COUNT + 1);
    localparam logic [COORD_WIDTH-1:0] SPEED = COORD_WIDTH'(MISSILE_SPEED);

    typedef enum logic [1:0] {StFree, StArmed, StFlying} slot_state_e;

    slot_state_e              state_q [MISSILE_COUNT];
    slot_state_e              state_d [MISSILE_COUNT];
    logic [COORD_WIDTH-1:0]   x_q     [MISSILE_COUNT];
    logic [COORD_WIDTH-1:0]   x_d     [MISSILE_COUNT];
    logic [COORD_WIDTH-1:0]   y_q     [MISSILE_COUNT];
    logic [COORD_WIDTH-1:0]   y_d     [MISSILE_COUNT];

    logic [MISSILE_COUNT-1:0] free_mask;
    logic [MISSILE_COUNT-1:0] alloc_sel;
    logic                     any_free;
    logic                     alloc_req;
    logic [COORD_WIDTH-1:0]   alloc_x;
    logic [COORD_WIDTH-1:0]   alloc_y;
    logic                     drop_d;
    logic [MISSILE_COUNT-1:0] active_d;
    logic [MISSILE_COUNT-1:0] active_q;
    logic [CNT_W-1:0]         count_d;
    logic [CNT_W-1:0]         count_q;
    logic                     drop_q;

    // Lowest-index FREE slot, judged on registered state only.
    always_comb begin
        logic taken;
        taken = 1'b0;
        for (int i = 0; i < MISSILE_COUNT; i++) begin
            free_mask[i] = (state_q[i] == StFree);
            alloc_sel[i] = free_mask[i] && !taken;
            taken        = taken || free_mask[i];
        end
        any_free = |free_mask;
    end

`ifdef MISSILE_FIRE_QUEUE_EN
    logic                   pend_valid_q, pend_valid_d;
    logic [COORD_WIDTH-1:0] pend_x_q, pend_x_d;
    logic [COORD_WIDTH-1:0] pend_y_q, pend_y_d;

    // Pending entry is older than any new request, so it wins the slot.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        alloc_req    = 1'b0;
        alloc_x      = spawn_x;
        alloc_y      = spawn_y;
        drop_d       = 1'b0;
        if (pend_valid_q) begin
            if (any_free) begin
                alloc_req = 1'b1;
                alloc_x   = pend_x_q;
                alloc_y   = pend_y_q;
                if (shooting_pulse) begin
                    pend_x_d = spawn_x;
                    pend_y_d = spawn_y;
                end else begin
                    pend_valid_d = 1'b0;
                end
            end else if (shooting_pulse) begin
                drop_d = 1'b1;
            end
        end else if (shooting_pulse) begin
            if (any_free) begin
                alloc_req = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_x_d     = spawn_x;
                pend_y_d     = spawn_y;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_valid_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
        end
    end
`else
    always_comb begin
        alloc_req = shooting_pulse && any_free;
        alloc_x   = spawn_x;
        alloc_y   = spawn_y;
        drop_d    = shooting_pulse && !any_free;
    end
`endif

    always_comb begin
        count_d = '0;
        for (int i = 0; i < MISSILE_COUNT; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            case (state_q[i])
                StFree: begin
                    if (alloc_req && alloc_sel[i]) begin
                        state_d[i] = StArmed;
                        x_d[i]     = alloc_x;
                        y_d[i]     = alloc_y;
                    end
                end
                StArmed: begin
                    if (missile_hit[i]) begin
                        state_d[i] = StFree;
                    end else if (startOfFrame) begin
                        state_d[i] = StFlying;
                    end
                end
                StFlying: begin
                    if (missile_hit[i]) begin
                        state_d[i] = StFree;
                    end else if (startOfFrame) begin
                        // Leaving the top frees the slot rather than wrapping Y.
                        if (y_q[i] < SPEED) begin
                            state_d[i] = StFree;
                        end else begin
                            y_d[i] = y_q[i] - SPEED;
                        end
                    end
                end
                default: state_d[i] = StFree;
            endcase
            active_d[i] = (state_d[i] != StFree);
            count_d     = count_d + CNT_W'(active_d[i]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < MISSILE_COUNT; i++) begin
                state_q[i] <= StFree;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
            active_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            for (int i = 0; i < MISSILE_COUNT; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
            active_q <= active_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        for (int i = 0; i < MISSILE_COUNT; i++) begin
            missile_x[i*COORD_WIDTH +: COORD_WIDTH] = x_q[i];
            missile_y[i*COORD_WIDTH +: COORD_WIDTH] = y_q[i];
        end
    end

    assign missile_active = active_q;
    assign active_count   = count_q;
    assign launch_dropped = drop_q;

endmodule

// File: tb/tb_missile_slot_allocator.sv
// Directed and randomized bench for missile_slot_allocator against a slot-list reference model.
// Model follows MISSILE_FIRE_QUEUE_EN when defined.
module tb_missile_slot_allocator;

    localparam int MC  = 4;
    localparam int CW  = 11;
    localparam int SPD = 4;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame;
    logic              shooting_pulse;
    logic [CW-1:0]     spawn_x;
    logic [CW-1:0]     spawn_y;
    logic [MC-1:0]     missile_hit;
    logic [MC-1:0]     missile_active;
    logic [MC*CW-1:0]  missile_x;
    logic [MC*CW-1:0]  missile_y;
    logic [2:0]        active_count;
    logic              launch_dropped;

    int checks = 0;
    int errors = 0;

    // Reference model: each slot is live/dead, armed/flying, with a position.
    bit            m_live [MC];
    bit            m_fly  [MC];
    logic [CW-1:0] m_x    [MC];
    logic [CW-1:0] m_y    [MC];
    bit            m_drop;
    bit            m_pend;
    logic [CW-1:0] m_pend_x, m_pend_y;

    missile_slot_allocator #(
        .MISSILE_COUNT(MC),
        .COORD_WIDTH  (CW),
        .MISSILE_SPEED(SPD)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .shooting_pulse(shooting_pulse),
        .spawn_x       (spawn_x),
        .spawn_y       (spawn_y),
        .missile_hit   (missile_hit),
        .missile_active(missile_active),
        .missile_x     (missile_x),
        .missile_y     (missile_y),
        .active_count  (active_count),
        .launch_dropped(launch_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MC; i++) begin
            m_live[i] = 0; m_fly[i] = 0; m_x[i] = '0; m_y[i] = '0;
        end
        m_drop = 0; m_pend = 0; m_pend_x = '0; m_pend_y = '0;
    endtask

    task automatic model_step(input bit sof, input bit pulse, input logic [CW-1:0] sx,
                              input logic [CW-1:0] sy, input logic [MC-1:0] hit);
        int            ff;
        bit            do_alloc;
        logic [CW-1:0] ax, ay;
        ff = -1;
        for (int i = MC - 1; i >= 0; i--) if (!m_live[i]) ff = i;
        for (int i = 0; i < MC; i++) begin
            if (m_live[i]) begin
                if (hit[i]) m_live[i] = 0;
                else if (sof) begin
                    if (!m_fly[i]) m_fly[i] = 1;
                    else if (int'(m_y[i]) < SPD) m_live[i] = 0;
                    else m_y[i] = CW'(int'(m_y[i]) - SPD);
                end
            end
        end
        m_drop = 0; do_alloc = 0; ax = sx; ay = sy;
`ifdef MISSILE_FIRE_QUEUE_EN
        if (m_pend) begin
            if (ff >= 0) begin
                do_alloc = 1; ax = m_pend_x; ay = m_pend_y;
                if (pulse) begin m_pend_x = sx; m_pend_y = sy; end
                else m_pend = 0;
            end else if (pulse) m_drop = 1;
        end else if (pulse) begin
            if (ff >= 0) do_alloc = 1;
            else begin m_pend = 1; m_pend_x = sx; m_pend_y = sy; end
        end
`else
        if (pulse) begin
            if (ff >= 0) do_alloc = 1;
            else m_drop = 1;
        end
`endif
        if (do_alloc) begin
            m_live[ff] = 1; m_fly[ff] = 0; m_x[ff] = ax; m_y[ff] = ay;
        end
    endtask

    task automatic check_all(input string tag);
        logic [MC-1:0]    ea;
        logic [MC*CW-1:0] ex, ey;
        int               cnt;
        cnt = 0;
        for (int i = 0; i < MC; i++) begin
            ea[i] = m_live[i];
            ex[i*CW +: CW] = m_x[i];
            ey[i*CW +: CW] = m_y[i];
            cnt += int'(m_live[i]);
        end
        check({tag, ".active"}, 64'(missile_active), 64'(ea));
        check({tag, ".count"}, 64'(active_count), 64'(cnt));
        check({tag, ".drop"}, 64'(launch_dropped), 64'(m_drop));
        check({tag, ".x"}, 64'(missile_x), 64'(ex));
        check({tag, ".y"}, 64'(missile_y), 64'(ey));
    endtask

    task automatic cycle(input string tag, input bit sof, input bit pulse, input int sx,
                         input int sy, input logic [MC-1:0] hit);
        startOfFrame   = sof;
        shooting_pulse = pulse;
        spawn_x        = CW'(sx);
        spawn_y        = CW'(sy);
        missile_hit    = hit;
        model_step(sof, pulse, CW'(sx), CW'(sy), hit);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        resetN = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        startOfFrame = 0; shooting_pulse = 0; spawn_x = '0; spawn_y = '0; missile_hit = '0;
        resetN = 1'b1;
        #2;
        do_reset("reset");

        // First shot and its first two frames.
        cycle("fire0", 0, 1, 100, 400, '0);
        check("fire0.act", 64'(missile_active), 64'h1);
        check("fire0.x", 64'(missile_x[CW-1:0]), 64'd100);
        check("fire0.y", 64'(missile_y[CW-1:0]), 64'd400);
        check("fire0.cnt", 64'(active_count), 64'd1);
        cycle("frame1", 1, 0, 0, 0, '0);
        check("frame1.y", 64'(missile_y[CW-1:0]), 64'd400);
        cycle("frame2", 1, 0, 0, 0, '0);
        check("frame2.y", 64'(missile_y[CW-1:0]), 64'd396);
        cycle("hit0", 0, 0, 0, 0, 4'b0001);

        // Near the top: Y=5 goes to 1, then the slot frees without wrapping.
        cycle("top.fire", 0, 1, 7, 5, '0);
        cycle("top.arm", 1, 0, 0, 0, '0);
        cycle("top.f1", 1, 0, 0, 0, '0);
        check("top.y1", 64'(missile_y[CW-1:0]), 64'd1);
        cycle("top.f2", 1, 0, 0, 0, '0);
        check("top.free", 64'(missile_active), 64'h0);
        check("top.cnt", 64'(active_count), 64'd0);
        check("top.nowrap", 64'(missile_y[CW-1:0]), 64'd1);

        // Fill the pool, then overflow.
        for (int i = 0; i < MC; i++) cycle("fill", 0, 1, 10 * i, 300 + i, '0);
        cycle("over", 0, 1, 555, 444, '0);
`ifdef MISSILE_FIRE_QUEUE_EN
        check("over.held", 64'(launch_dropped), 64'd0);
        cycle("qhit", 0, 0, 0, 0, 4'b0100);
        cycle("qrefill", 0, 0, 0, 0, '0);
        check("qrefill.x", 64'(missile_x[2*CW +: CW]), 64'd555);
        check("qrefill.y", 64'(missile_y[2*CW +: CW]), 64'd444);
`else
        check("over.drop", 64'(launch_dropped), 64'd1);
        cycle("over.end", 0, 0, 0, 0, '0);
        check("over.pulse", 64'(launch_dropped), 64'd0);
        cycle("hit2", 0, 0, 0, 0, 4'b0100);
`endif
        // Leave only slot 1, then hit it while firing.
        cycle("hit023", 0, 0, 0, 0, 4'b1101);
        cycle("hitfire", 0, 1, 33, 300, 4'b0010);
        check("hitfire.low", 64'(missile_active[1:0]), 64'h1);

        // Fire on the same cycle as startOfFrame: slot 1 armed, moves two frames later.
        cycle("cofire", 1, 1, 44, 200, '0);
        check("cofire.y", 64'(missile_y[CW +: CW]), 64'd200);
        cycle("cof1", 1, 0, 0, 0, '0);
        check("cof1.y", 64'(missile_y[CW +: CW]), 64'd200);
        cycle("cof2", 1, 0, 0, 0, '0);
        check("cof2.y", 64'(missile_y[CW +: CW]), 64'd196);

        // Reset mid-flight with three live missiles.
        cycle("third", 0, 1, 55, 500, '0);
        cycle("fly3", 1, 0, 0, 0, '0);
        check("fly3.cnt", 64'(active_count), 64'd3);
        do_reset("midreset");
        check("midreset.act", 64'(missile_active), 64'h0);
        cycle("post", 0, 1, 1, 2, '0);
        check("post.act", 64'(missile_active), 64'h1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bit            sof, pul;
            logic [MC-1:0] h;
            sof = ($urandom_range(0, 3) == 0);
            pul = ($urandom_range(0, 2) == 0);
            h   = ($urandom_range(0, 7) == 0) ? MC'($urandom) : '0;
            cycle("rand", sof, pul, int'($urandom_range(0, 2047)), int'($urandom_range(0, 40)), h);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
